// File: rtl/gth_tmds_lane_gearbox.sv
// TMDS symbol FIFO/packer feeding the GTH TX userdata bus: primes a beat FIFO, then
// emits one word per lane per txusrclk2 cycle, with an optional clock lane and per-lane inversion.
module gth_tmds_lane_gearbox #(
    parameter int NUM_CH        = 3,
    parameter int SYM_W         = 10,
    parameter int SYMS_PER_WORD = 2,
    parameter int FIFO_DEPTH    = 16,
    parameter int PRIME_LVL     = 4,
    parameter int CLK_LANE      = 1,
    parameter logic [NUM_CH+CLK_LANE-1:0] INV_MASK = '0,
    parameter logic [SYM_W-1:0] IDLE_SYM = 10'h354,
    localparam int TX_W  = SYM_W * SYMS_PER_WORD,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tx_reset_done,
    input  logic [NUM_CH*TX_W-1:0]          sym_data,
    input  logic                            sym_valid,
    output logic                            sym_ready,
    output logic [(NUM_CH+CLK_LANE)*TX_W-1:0] tx_data,
    output logic                            tx_active,
    output logic [LVL_W-1:0]                fifo_level,
    output logic [15:0]                     underflow_cnt
);
    localparam int OUT_LANES = NUM_CH + CLK_LANE;
    localparam int BEAT_W    = NUM_CH * TX_W;
    localparam int OUT_W     = OUT_LANES * TX_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] PRIME_THR = LVL_W'(PRIME_LVL);
    localparam logic [SYM_W-1:0] CLK_SYM   = {SYM_W{1'b1}} >> (SYM_W / 2);
    localparam logic [TX_W-1:0]  IDLE_WORD = {SYMS_PER_WORD{IDLE_SYM}};
    localparam logic [TX_W-1:0]  CLK_WORD  = {SYMS_PER_WORD{CLK_SYM}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]        underflow_q, underflow_d;
    logic [OUT_W-1:0]   tx_data_q, tx_data_d;
    logic               tx_active_q, tx_active_d;
    logic [BEAT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]   raw;
    logic [OUT_W-1:0]   inv_bits;
    logic               push, pop;

    assign sym_ready     = (state_q != IDLE) && (level_q < DEPTH_LVL);
    assign push          = sym_valid && sym_ready;
    assign pop           = (state_q == RUN) && (level_q != '0) && tx_reset_done;
    assign tx_data       = tx_data_q;
    assign tx_active     = tx_active_q;
    assign fifo_level    = level_q;
    assign underflow_cnt = underflow_q;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        underflow_d = underflow_q;
        raw         = '0;
        inv_bits    = '0;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);

        case (state_q)
            IDLE:    if (tx_reset_done) state_d = PRIME;
            PRIME:   if (level_q >= PRIME_THR) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (state_q == RUN && tx_reset_done && level_q == '0 && underflow_q != 16'hFFFF)
            underflow_d = underflow_q + 16'd1;

        // Losing the GTH reset-done drops straight to IDLE and discards everything buffered
        if (!tx_reset_done) begin
            state_d  = IDLE;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        for (int c = 0; c < NUM_CH; c++) raw[c*TX_W +: TX_W] = IDLE_WORD;
        if (pop) raw[BEAT_W-1:0] = mem_q[rd_ptr_q];
        for (int l = NUM_CH; l < OUT_LANES; l++)
            raw[l*TX_W +: TX_W] = (state_d != IDLE) ? CLK_WORD : '0;

        for (int l = 0; l < OUT_LANES; l++) inv_bits[l*TX_W +: TX_W] = {TX_W{INV_MASK[l]}};
        tx_data_d   = raw ^ inv_bits;
        tx_active_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= '0;
            tx_data_q   <= '0;
            tx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
            tx_data_q   <= tx_data_d;
            tx_active_q <= tx_active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sym_data;
    end
endmodule

// File: tb/tb_gth_tmds_lane_gearbox.sv
// Directed bench for gth_tmds_lane_gearbox: default instance A, and instance B with
// PRIME_LVL=16 and lane 1 inverted, exercised one after the other on shared inputs.
module tb_gth_tmds_lane_gearbox;
    localparam logic [19:0] IDLE_WORD = 20'hD5354;
    localparam logic [19:0] CLK_WORD  = 20'h07C1F;
    localparam logic [59:0] IDLE_DATA = {3{IDLE_WORD}};
    localparam logic [3:0]  MASK_B    = 4'b0010;

    logic        clk = 1'b0;
    logic        reset_a, reset_b, done, sym_valid;
    logic [59:0] sym_data;
    logic        a_ready, b_ready, a_active, b_active;
    logic [79:0] a_tx, b_tx;
    logic [4:0]  a_level, b_level;
    logic [15:0] a_ucnt, b_ucnt;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    gth_tmds_lane_gearbox dut_a (
        .clk(clk), .reset(reset_a), .tx_reset_done(done), .sym_data(sym_data),
        .sym_valid(sym_valid), .sym_ready(a_ready), .tx_data(a_tx), .tx_active(a_active),
        .fifo_level(a_level), .underflow_cnt(a_ucnt)
    );

    gth_tmds_lane_gearbox #(.PRIME_LVL(16), .INV_MASK(MASK_B)) dut_b (
        .clk(clk), .reset(reset_b), .tx_reset_done(done), .sym_data(sym_data),
        .sym_valid(sym_valid), .sym_ready(b_ready), .tx_data(b_tx), .tx_active(b_active),
        .fifo_level(b_level), .underflow_cnt(b_ucnt)
    );

    task automatic checkOutput(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [59:0] d, input logic dn);
        sym_valid = v;
        sym_data  = d;
        done      = dn;
        @(posedge clk);
        #1;
    endtask

    // Lane c slot s of beat k carries {c, s, k}
    function automatic logic [59:0] beat(input int k);
        logic [59:0] b;
        b = '0;
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < 2; s++)
                b[c*20 + s*10 +: 10] = {2'(c), 1'(s), 7'(k)};
        return b;
    endfunction

    function automatic logic [79:0] word(input logic [59:0] d, input bit clk_on, input logic [3:0] mask);
        logic [79:0] w;
        w = {clk_on ? CLK_WORD : 20'h0, d};
        for (int l = 0; l < 4; l++)
            if (mask[l]) w[l*20 +: 20] = ~w[l*20 +: 20];
        return w;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        done = 1'b0;
        sym_valid = 1'b0;
        sym_data = '0;

        // Reset held with valid asserted: nothing accepted
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, beat(0), 1'b0);
            checkOutput("rst_ready", 80'(a_ready), 80'(0));
        end
        checkOutput("rst_tx", a_tx, 80'h0);
        checkOutput("rst_level", 80'(a_level), 80'(0));
        checkOutput("rst_active", 80'(a_active), 80'(0));
        checkOutput("rst_ucnt", 80'(a_ucnt), 80'(0));
        reset_a = 1'b0;
        #1;
        checkOutput("first_tx_zero", a_tx, 80'h0);
        applyStimulus(1'b1, beat(0), 1'b0);
        checkOutput("idle_tx", a_tx, word(IDLE_DATA, 1'b0, 4'b0));
        checkOutput("idle_ready", 80'(a_ready), 80'(0));
        checkOutput("idle_level", 80'(a_level), 80'(0));

        // Prime and stream beats 0..7
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("prime_tx", a_tx, word(IDLE_DATA, 1'b1, 4'b0));
        checkOutput("prime_active", 80'(a_active), 80'(0));
        checkOutput("prime_ready", 80'(a_ready), 80'(1));
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, beat(k), 1'b1);
            if (k == 3) begin
                checkOutput("lvl4_level", 80'(a_level), 80'(4));
                checkOutput("lvl4_active", 80'(a_active), 80'(0));
            end
            if (k == 4) begin
                checkOutput("run_level", 80'(a_level), 80'(5));
                checkOutput("run_active", 80'(a_active), 80'(1));
                checkOutput("run_first_tx", a_tx, word(IDLE_DATA, 1'b1, 4'b0));
            end
            if (k >= 5) checkOutput("stream_tx", a_tx, word(beat(k - 5), 1'b1, 4'b0));
        end
        for (int k = 3; k < 8; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("drain_tx", a_tx, word(beat(k), 1'b1, 4'b0));
        end
        checkOutput("drain_level", 80'(a_level), 80'(0));
        checkOutput("drain_ucnt", 80'(a_ucnt), 80'(0));

        // Underflow in RUN inserts idle words and counts them
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("uflow_tx", a_tx, word(IDLE_DATA, 1'b1, 4'b0));
            checkOutput("uflow_ucnt", 80'(a_ucnt), 80'(i));
        end
        applyStimulus(1'b1, beat(20), 1'b1);
        checkOutput("b20_idle_tx", a_tx, word(IDLE_DATA, 1'b1, 4'b0));
        checkOutput("b20_ucnt", 80'(a_ucnt), 80'(3));
        applyStimulus(1'b1, beat(21), 1'b1);
        checkOutput("b20_tx", a_tx, word(beat(20), 1'b1, 4'b0));
        applyStimulus(1'b1, beat(22), 1'b1);
        checkOutput("b21_tx", a_tx, word(beat(21), 1'b1, 4'b0));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("b22_tx", a_tx, word(beat(22), 1'b1, 4'b0));
        checkOutput("b22_ucnt", 80'(a_ucnt), 80'(3));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_tx", a_tx, word(IDLE_DATA, 1'b1, 4'b0));
        checkOutput("post_ucnt", 80'(a_ucnt), 80'(4));
        checkOutput("post_active", 80'(a_active), 80'(1));

        // Drop reset-done from RUN, then re-prime and drop it again with level 5
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drop0_active", 80'(a_active), 80'(0));
        checkOutput("drop0_tx", a_tx, word(IDLE_DATA, 1'b0, 4'b0));
        checkOutput("drop0_ucnt", 80'(a_ucnt), 80'(4));
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 30; k < 35; k++) applyStimulus(1'b1, beat(k), 1'b1);
        checkOutput("lvl5_level", 80'(a_level), 80'(5));
        checkOutput("lvl5_active", 80'(a_active), 80'(1));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drop_active", 80'(a_active), 80'(0));
        checkOutput("drop_level", 80'(a_level), 80'(0));
        checkOutput("drop_ready", 80'(a_ready), 80'(0));
        checkOutput("drop_tx", a_tx, word(IDLE_DATA, 1'b0, 4'b0));
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 40; k < 45; k++) applyStimulus(1'b1, beat(k), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("reprime_tx", a_tx, word(beat(40), 1'b1, 4'b0));
        checkOutput("reprime_ucnt", 80'(a_ucnt), 80'(4));

        // Asynchronous reset clears outputs before the next edge
        reset_a = 1'b1;
        #1;
        checkOutput("async_tx", a_tx, 80'h0);
        checkOutput("async_active", 80'(a_active), 80'(0));
        checkOutput("async_level", 80'(a_level), 80'(0));
        checkOutput("async_ucnt", 80'(a_ucnt), 80'(0));

        // Instance B: fill to 16 in PRIME, reject a 17th beat, drain in order with lane 1 inverted
        reset_b = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("b_idle_tx", b_tx, word(IDLE_DATA, 1'b0, MASK_B));
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, beat(50 + k), 1'b1);
        checkOutput("b_full_level", 80'(b_level), 80'(16));
        checkOutput("b_full_ready", 80'(b_ready), 80'(0));
        checkOutput("b_full_active", 80'(b_active), 80'(0));
        applyStimulus(1'b1, beat(99), 1'b1);
        checkOutput("b_17th_level", 80'(b_level), 80'(16));
        checkOutput("b_17th_active", 80'(b_active), 80'(1));
        checkOutput("b_17th_tx", b_tx, word(IDLE_DATA, 1'b1, MASK_B));
        applyStimulus(1'b1, beat(99), 1'b1);
        checkOutput("b_pop_tx", b_tx, word(beat(50), 1'b1, MASK_B));
        checkOutput("b_pop_level", 80'(b_level), 80'(15));
        applyStimulus(1'b1, beat(66), 1'b1);
        checkOutput("b_pp_tx", b_tx, word(beat(51), 1'b1, MASK_B));
        checkOutput("b_pp_level", 80'(b_level), 80'(15));
        applyStimulus(1'b1, beat(67), 1'b1);
        checkOutput("b_pp2_tx", b_tx, word(beat(52), 1'b1, MASK_B));
        checkOutput("b_pp2_level", 80'(b_level), 80'(15));
        for (int k = 53; k < 68; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("b_drain_tx", b_tx, word(beat(k), 1'b1, MASK_B));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("b_uflow_tx", b_tx, word(IDLE_DATA, 1'b1, MASK_B));
        checkOutput("b_uflow_ucnt", 80'(b_ucnt), 80'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
